// File: rtl/fa_core_if.sv
// Operand/result bundle for fa_core: the master drives operands and in_valid,
// the slave returns the combinational and registered results.
// With FA_OVERFLOW_EN defined, the bundle also carries overflow and overflow_q.
interface fa_core_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             carry_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             out_valid;
`ifdef FA_OVERFLOW_EN
  logic             overflow;
  logic             overflow_q;

  modport master (
    output input1, input2, carry_in, in_valid,
    input  sum, carry_out, sum_q, carry_out_q, out_valid, overflow, overflow_q
  );
  modport slave (
    input  input1, input2, carry_in, in_valid,
    output sum, carry_out, sum_q, carry_out_q, out_valid, overflow, overflow_q
  );
`else
  modport master (
    output input1, input2, carry_in, in_valid,
    input  sum, carry_out, sum_q, carry_out_q, out_valid
  );
  modport slave (
    input  input1, input2, carry_in, in_valid,
    output sum, carry_out, sum_q, carry_out_q, out_valid
  );
`endif
endinterface

// File: rtl/fa_core.sv
// WIDTH-bit ripple-carry adder: a combinational sum/carry path and a registered copy with a valid flag.
// Defining FA_OVERFLOW_EN adds the signed overflow output and its registered copy.
module fa_core #(
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  fa_core_if.slave   bus
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_w;

  assign c[0] = bus.carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_w[i] = bus.input1[i] ^ bus.input2[i] ^ c[i];
    assign c[i+1]   = (bus.input1[i] & bus.input2[i]) |
                      (bus.input1[i] & c[i]) |
                      (bus.input2[i] & c[i]);
  end

  assign bus.sum       = sum_w;
  assign bus.carry_out = c[WIDTH];

`ifdef FA_OVERFLOW_EN
  logic ovf_w;
  logic ovf_r_d, ovf_r_q;

  // At WIDTH=1, c[WIDTH-1] is c[0], which is carry_in
  assign ovf_w        = c[WIDTH] ^ c[WIDTH-1];
  assign bus.overflow = ovf_w;
`endif

  logic [WIDTH-1:0] sum_r_d, sum_r_q;
  logic             cout_r_d, cout_r_q;
  logic             valid_d, valid_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sum_r_d  = sum_r_q;
    cout_r_d = cout_r_q;
    valid_d  = 1'b0;
`ifdef FA_OVERFLOW_EN
    ovf_r_d  = ovf_r_q;
`endif
    if (bus.in_valid) begin
      sum_r_d  = sum_w;
      cout_r_d = c[WIDTH];
      valid_d  = 1'b1;
`ifdef FA_OVERFLOW_EN
      ovf_r_d  = ovf_w;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r_q  <= '0;
      cout_r_q <= 1'b0;
      valid_q  <= 1'b0;
`ifdef FA_OVERFLOW_EN
      ovf_r_q  <= 1'b0;
`endif
    end else begin
      sum_r_q  <= sum_r_d;
      cout_r_q <= cout_r_d;
      valid_q  <= valid_d;
`ifdef FA_OVERFLOW_EN
      ovf_r_q  <= ovf_r_d;
`endif
    end
  end

  assign bus.sum_q       = sum_r_q;
  assign bus.carry_out_q = cout_r_q;
  assign bus.out_valid   = valid_q;
`ifdef FA_OVERFLOW_EN
  assign bus.overflow_q  = ovf_r_q;
`endif

endmodule

// File: tb/tb_fa_core.sv
// Directed self-checking bench for fa_core at WIDTH=1 and WIDTH=8.
// Checks the overflow outputs when FA_OVERFLOW_EN is defined.
module tb_fa_core;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fa_core_if #(.WIDTH(1)) bus1 ();
  fa_core_if #(.WIDTH(8)) bus8 ();

  fa_core #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  fa_core #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive1(input logic a, input logic b, input logic ci, input logic v);
    bus1.input1   = a;
    bus1.input2   = b;
    bus1.carry_in = ci;
    bus1.in_valid = v;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v);
    bus8.input1   = a;
    bus8.input2   = b;
    bus8.carry_in = ci;
    bus8.in_valid = v;
  endtask

  // Expected responses indexed by {input1,input2,carry_in}
  logic [7:0] exp_sum;
  logic [7:0] exp_cout;
  logic [2:0] vec;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_sum  = 8'h96;
    exp_cout = 8'hE8;
    rst_n    = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    check("w1_reset_sum_q",     bus1.sum_q,       1'b0);
    check("w1_reset_cout_q",    bus1.carry_out_q, 1'b0);
    check("w1_reset_out_valid", bus1.out_valid,   1'b0);
    check("w8_reset_sum_q",     bus8.sum_q,       8'h00);
    check("w8_reset_out_valid", bus8.out_valid,   1'b0);

    for (int v = 0; v < 8; v++) begin
      vec = v[2:0];
      drive1(vec[2], vec[1], vec[0], 1'b0);
      #40;
      check($sformatf("w1_sum_%0d", v),  bus1.sum,       exp_sum[v]);
      check($sformatf("w1_cout_%0d", v), bus1.carry_out, exp_cout[v]);
    end

    // Combinational path works while reset is held
    drive1(1'b1, 1'b0, 1'b1, 1'b1);
    #40;
    check("rst_comb_sum",      bus1.sum,       1'b0);
    check("rst_comb_cout",     bus1.carry_out, 1'b1);
    check("rst_sum_q",         bus1.sum_q,     1'b0);
    check("rst_out_valid",     bus1.out_valid, 1'b0);

    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_valid", bus1.out_valid, 1'b0);

    // One-cycle latency, then hold with in_valid low
    drive1(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("lat_sum_q",     bus1.sum_q,       1'b0);
    check("lat_cout_q",    bus1.carry_out_q, 1'b1);
    check("lat_out_valid", bus1.out_valid,   1'b1);
    drive1(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("hold_out_valid", bus1.out_valid,   1'b0);
    check("hold_sum_q",     bus1.sum_q,       1'b0);
    check("hold_cout_q",    bus1.carry_out_q, 1'b1);

    // Async reset between edges clears the registered stage
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("pre_arst_sum_q",     bus1.sum_q,       1'b1);
    check("pre_arst_cout_q",    bus1.carry_out_q, 1'b1);
    check("pre_arst_out_valid", bus1.out_valid,   1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sum_q",     bus1.sum_q,       1'b0);
    check("arst_cout_q",    bus1.carry_out_q, 1'b0);
    check("arst_out_valid", bus1.out_valid,   1'b0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=8 wrap-around and signed overflow
    drive8(8'hFF, 8'h01, 1'b0, 1'b0);
    #10;
    check("w8_wrap_sum",  bus8.sum,       8'h00);
    check("w8_wrap_cout", bus8.carry_out, 1'b1);
`ifdef FA_OVERFLOW_EN
    check("w8_wrap_ovf",  bus8.overflow,  1'b0);
`endif
    drive8(8'h7F, 8'h00, 1'b1, 1'b0);
    #10;
    check("w8_7f_sum",  bus8.sum,       8'h80);
    check("w8_7f_cout", bus8.carry_out, 1'b0);
`ifdef FA_OVERFLOW_EN
    check("w8_7f_ovf",  bus8.overflow,  1'b1);
`endif

    // Back-to-back captures
    @(negedge clk);
    drive8(8'h05, 8'h03, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("b2b_0_sum_q",     bus8.sum_q,     8'h08);
    check("b2b_0_out_valid", bus8.out_valid, 1'b1);
    drive8(8'h10, 8'h20, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("b2b_1_sum_q",     bus8.sum_q,       8'h31);
    check("b2b_1_cout_q",    bus8.carry_out_q, 1'b0);
    check("b2b_1_out_valid", bus8.out_valid,   1'b1);
    drive8(8'h7F, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("b2b_2_sum_q",     bus8.sum_q,     8'h80);
    check("b2b_2_out_valid", bus8.out_valid, 1'b1);
`ifdef FA_OVERFLOW_EN
    check("b2b_2_ovf_q",     bus8.overflow_q, 1'b1);
`endif
    drive8(8'hFF, 8'hFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("w8_hold_out_valid", bus8.out_valid,   1'b0);
    check("w8_hold_sum_q",     bus8.sum_q,       8'h80);
    check("w8_hold_cout_q",    bus8.carry_out_q, 1'b0);
`ifdef FA_OVERFLOW_EN
    check("w8_hold_ovf_q",     bus8.overflow_q,  1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
